mdu_div_ctrl: RTL and testbench

MDU_DIV_CTRL -- requirements
Module: mdu_div_ctrl

---
 rtl/mdu_div_ctrl_pkg.sv | 19 +
 rtl/mdu_div_ctrl_div_core.sv | 52 +++++
 rtl/mdu_div_ctrl.sv | 105 ++++++++++
 tb/tb_mdu_div_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_div_ctrl_pkg.sv
// Shared types and constants for the iterative divide unit:
// FSM encoding, iteration count and the divide-by-zero quotient.
package mdu_div_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int          DIV_CYCLES = 32;
    localparam logic [31:0] DIVZERO_Q  = 32'hFFFFFFFF;

    // Two's-complement negate when neg is set; used for magnitudes and sign fix-up.
    function automatic logic [31:0] cond_neg(input logic [31:0] value, input logic neg);
        return neg ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/mdu_div_ctrl_div_core.sv
// Radix-2 restoring divider on unsigned magnitudes: one shift/subtract per step.
// quotient/remainder present the result of the step being applied this cycle.
module div_core
    import mdu_div_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        last
);

    logic [63:0] acc_reg;
    logic [31:0] divisor_reg;
    logic [5:0]  count_reg;

    logic [32:0] shifted_hi;
    logic [33:0] diff;
    logic        fits;
    logic [63:0] acc_next;

    // The partial remainder can transiently need 33 bits after the shift.
    always_comb begin
        shifted_hi = acc_reg[63:31];
        diff       = {1'b0, shifted_hi} - {2'b00, divisor_reg};
        fits       = ~diff[33];
        acc_next   = {(fits ? diff[31:0] : shifted_hi[31:0]), acc_reg[30:0], fits};
        quotient   = acc_next[31:0];
        remainder  = acc_next[63:32];
        last       = (count_reg == 6'(DIV_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg     <= '0;
            divisor_reg <= '0;
            count_reg   <= '0;
        end else if (load) begin
            acc_reg     <= {32'd0, dividend};
            divisor_reg <= divisor;
            count_reg   <= '0;
        end else if (step) begin
            acc_reg     <= acc_next;
            count_reg   <= count_reg + 6'd1;
        end
    end

endmodule

// File: rtl/mdu_div_ctrl.sv
// Divide controller for the EX stage: FSM, pipeline stall, sign handling,
// divide-by-zero bypass, flush and the HI/LO result registers.
module mdu_div_ctrl
    import mdu_div_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        div_req,
    input  logic        signed_i,
    input  logic [31:0] opa_i,
    input  logic [31:0] opb_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] lo_o,
    output logic [31:0] hi_o
);

    state_t      state_reg;
    logic        neg_q_reg;
    logic        neg_r_reg;
    logic [31:0] lo_reg;
    logic [31:0] hi_reg;

    logic        start;
    logic        div_zero;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        core_load;
    logic        core_step;
    logic [31:0] core_q;
    logic [31:0] core_r;
    logic        core_last;

    always_comb begin
        start     = (state_reg == IDLE) && div_req && !flush_i;
        div_zero  = (opb_i == 32'd0);
        a_neg     = signed_i && opa_i[31];
        b_neg     = signed_i && opb_i[31];
        mag_a     = cond_neg(opa_i, a_neg);
        mag_b     = cond_neg(opb_i, b_neg);
        core_load = start && !div_zero;
        core_step = (state_reg == CALC) && !flush_i;
    end

    div_core u_div_core (
        .clk       (clk),
        .rst       (rst),
        .load      (core_load),
        .step      (core_step),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .quotient  (core_q),
        .remainder (core_r),
        .last      (core_last)
    );

    // Gated by rst so a request held through reset cannot stall or signal.
    assign stall_o = !rst && (start || (state_reg == CALC));
    assign busy_o  = !rst && (state_reg == CALC);
    assign done_o  = !rst && (state_reg == DONE) && !flush_i;
    assign lo_o    = lo_reg;
    assign hi_o    = hi_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            lo_reg    <= '0;
            hi_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (div_zero) begin
                            lo_reg    <= DIVZERO_Q;
                            hi_reg    <= opa_i;
                            state_reg <= DONE;
                        end else begin
                            neg_q_reg <= a_neg ^ b_neg;
                            neg_r_reg <= a_neg;
                            state_reg <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush_i) begin
                        state_reg <= IDLE;
                    end else if (core_last) begin
                        lo_reg    <= cond_neg(core_q, neg_q_reg);
                        hi_reg    <= cond_neg(core_r, neg_r_reg);
                        state_reg <= DONE;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_div_ctrl.sv
// Directed bench for mdu_div_ctrl: the issuer pushes expected HI/LO and the
// done cycle into a queue; a negedge monitor pops and compares on done_o.
module tb_mdu_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_req;
    logic        signed_i;
    logic [31:0] opa_i;
    logic [31:0] opb_i;
    logic        flush_i;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] lo_o;
    logic [31:0] hi_o;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [31:0] last_lo = '0;
    logic [31:0] last_hi = '0;

    mdu_div_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .div_req  (div_req),
        .signed_i (signed_i),
        .opa_i    (opa_i),
        .opb_i    (opb_i),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .lo_o     (lo_o),
        .hi_o     (hi_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: every done_o pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done at cyc %0d: lo=%h hi=%h", cyc, lo_o, hi_o);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("lo", lo_o, e.lo);
                chk("hi", hi_o, e.hi);
                $display("div done cyc=%0d lo=%h hi=%h", cyc, lo_o, hi_o);
            end
        end
    end

    task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] el, input logic [31:0] eh, output int t);
        exp_t e;
        @(posedge clk); #1;
        div_req  = 1'b1;
        signed_i = s;
        opa_i    = a;
        opb_i    = b;
        t        = cyc;
        e.lo = el; e.hi = eh; e.cyc = t + ((b == 0) ? 1 : 33);
        sb_q.push_back(e);
        last_lo = el;
        last_hi = eh;
        #1 chk("stall_on_req", 32'(stall_o), 32'd1);
        $display("div issue cyc=%0d signed=%0d a=%h b=%h exp lo=%h hi=%h", t, s, a, b, el, eh);
    endtask

    // Checks stall/busy each cycle until the expected done cycle.
    task automatic wait_result(input int t, input bit zero);
        int lat;
        lat = zero ? 1 : 33;
        @(posedge clk); #1;
        div_req = 1'b0;
        while (cyc < t + lat) begin
            chk("stall_calc", 32'(stall_o), 32'd1);
            chk("busy_calc", 32'(busy_o), 32'd1);
            @(posedge clk); #1;
        end
        chk("stall_done", 32'(stall_o), 32'd0);
        chk("busy_done", 32'(busy_o), 32'd0);
        chk("done_pulse", 32'(done_o), 32'd1);
    endtask

    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] el, input logic [31:0] eh);
        int t;
        issue(s, a, b, el, eh, t);
        wait_result(t, b == 0);
    endtask

    initial begin
        int t;
        rst = 1'b1; div_req = 1'b0; signed_i = 1'b0;
        opa_i = '0; opb_i = '0; flush_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_lo", lo_o, 32'd0);
        chk("rst_hi", hi_o, 32'd0);
        rst = 1'b0;

        run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
        run_div(1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5);
        run_div(1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF);
        run_div(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1);
        run_div(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE);
        run_div(1'b1, 32'hFFFFFFF0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFF0);

        // Flush mid-CALC: nothing queued, result registers must hold.
        @(posedge clk); #1;
        div_req = 1'b1; signed_i = 1'b0; opa_i = 32'd1000; opb_i = 32'd3;
        t = cyc;
        $display("flush issue cyc=%0d", t);
        @(posedge clk); #1;
        div_req = 1'b0;
        while (cyc < t + 10) begin
            @(posedge clk); #1;
        end
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        chk("flush_busy", 32'(busy_o), 32'd0);
        chk("flush_stall", 32'(stall_o), 32'd0);
        chk("flush_lo_hold", lo_o, last_lo);
        chk("flush_hi_hold", hi_o, last_hi);
        run_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0);

        // Reset mid-CALC with div_req held high through reset.
        @(posedge clk); #1;
        div_req = 1'b1; signed_i = 1'b0; opa_i = 32'd50; opb_i = 32'd5;
        t = cyc;
        $display("reset issue cyc=%0d", t);
        @(posedge clk); #1;
        div_req = 1'b0;
        while (cyc < t + 5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        div_req = 1'b1;
        #1 chk("rst_mid_stall", 32'(stall_o), 32'd0);
        @(posedge clk); #1;
        chk("rst_mid_busy", 32'(busy_o), 32'd0);
        chk("rst_mid_done", 32'(done_o), 32'd0);
        chk("rst_mid_lo", lo_o, 32'd0);
        chk("rst_mid_hi", hi_o, 32'd0);
        @(posedge clk); #1;
        chk("rst_hold_stall", 32'(stall_o), 32'd0);
        chk("rst_hold_busy", 32'(busy_o), 32'd0);
        rst = 1'b0;
        begin
            exp_t e;
            t = cyc;
            e.lo = 32'd10; e.hi = 32'd0; e.cyc = t + 33;
            sb_q.push_back(e);
            #1 chk("post_rst_stall", 32'(stall_o), 32'd1);
            $display("post-reset issue cyc=%0d a=50 b=5", t);
        end
        wait_result(t, 1'b0);

        repeat (3) @(posedge clk);
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
